tx_uart_controller: RTL and testbench

Transmit controller that consumes the one-cycle send pulse from the transmit single pulser and serialises one parallel byte onto a UART line (8N1, LSB first). It sits directly downstream of the pulser and drives the board's serial TX pin. It reports `busy` while a frame is in flight and `done` for one cycle when a frame completes.

---
 rtl/tx_pkg.sv | 10 +
 rtl/tx_baud_counter.sv | 19 +
 rtl/tx_uart_controller.sv | 70 +++++++
 tb/tb_tx_uart_controller.sv | 104 ++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// tx_pkg: shared state encoding and default bit timing for the UART transmitter
package tx_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;
   localparam int CLKS_PER_BIT_DEF = 434;
endpackage

// File: rtl/tx_baud_counter.sv
// tx_baud_counter: bit-period counter pulsing tick on its terminal count
import tx_pkg::*;
module tx_baud_counter #(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);
   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
   logic [W-1:0] r_cnt;
   assign tick = r_cnt == LAST;
   always_ff @(posedge clk) begin
      if (reset || clear || tick) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/tx_uart_controller.sv
// tx_uart_controller: 8N1 LSB-first UART transmitter started by a one-cycle send pulse
import tx_pkg::*;
module tx_uart_controller #(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send_pulse,
   input  logic [7:0] data_in,
   output logic       tx_out,
   output logic       busy,
   output logic       done
);
   tx_state_t  r_state, w_next;
   logic [7:0] r_shift, w_shift_next;
   logic [2:0] r_idx, w_idx_next;
   logic       r_tx, r_busy, r_done;
   logic       w_tick, w_tx_next;
   tx_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (r_state == IDLE),
      .tick  (w_tick)
   );
   always_comb begin
      w_next       = r_state;
      w_shift_next = r_shift;
      w_idx_next   = r_idx;
      case (r_state)
         IDLE:  if (send_pulse) begin
                   w_next       = START;
                   w_shift_next = data_in;
                   w_idx_next   = 3'd0;
                end
         START: if (w_tick) begin
                   w_next     = DATA;
                   w_idx_next = 3'd0;
                end
         DATA:  if (w_tick) begin
                   w_next     = (r_idx == 3'd7) ? STOP : DATA;
                   w_idx_next = r_idx + 3'd1;
                end
         STOP:  if (w_tick) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      // Line level is registered from the next state so it changes on the same edge as the state
      w_tx_next = (w_next == START) ? 1'b0 :
                  (w_next == DATA)  ? w_shift_next[w_idx_next] : 1'b1;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_shift <= w_shift_next;
         r_idx   <= w_idx_next;
         r_tx    <= w_tx_next;
         r_busy  <= w_next != IDLE;
         r_done  <= (r_state == STOP) && w_tick;
      end
   end
   assign tx_out = r_tx;
   assign busy   = r_busy;
   assign done   = r_done;
endmodule

// File: tb/tb_tx_uart_controller.sv
// tb_tx_uart_controller: randomized and directed frames checked against a frame-timing model
module tb_tx_uart_controller;
   localparam int C = 4;
   logic       clk = 1'b0, reset = 1'b1, send_pulse = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       tx_out, busy, done;
   int         n_chk = 0, n_pass = 0, n = 0, t0 = 0, busy_cnt = 0, done_cnt = 0;
   bit         have = 1'b0;
   logic [7:0] mbyte = 8'h00;
   tx_uart_controller #(.CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .reset      (reset),
      .send_pulse (send_pulse),
      .data_in    (data_in),
      .tx_out     (tx_out),
      .busy       (busy),
      .done       (done)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
   endtask
   // Frame model: a frame accepted at edge t0 puts the line at offset (n - t0) into the 10-bit frame
   task automatic cyc(input bit r, input bit p, input logic [7:0] d);
      int off;
      bit idle, e_tx, e_busy, e_done;
      reset = r;
      send_pulse = p;
      data_in = d;
      @(posedge clk);
      n++;
      idle = !(have && (n - 1 - t0) < 10 * C);
      if (r) have = 1'b0;
      else if (p && idle) begin
         have  = 1'b1;
         t0    = n;
         mbyte = d;
      end
      #1;
      off = n - t0;
      e_tx = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (have) begin
         e_busy = off < 10 * C;
         e_done = off == 10 * C;
         if (off < C) e_tx = 1'b0;
         else if (off < 9 * C) e_tx = mbyte[(off - C) / C];
      end
      check("tx_out", int'(tx_out), int'(e_tx));
      check("busy", int'(busy), int'(e_busy));
      check("done", int'(done), int'(e_done));
      busy_cnt += int'(busy);
      done_cnt += int'(done);
   endtask
   task automatic idle_run(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 8'($urandom));
   endtask
   initial begin
      repeat (3) cyc(1'b1, 1'b0, 8'h00);
      busy_cnt = 0; done_cnt = 0;
      idle_run(20);
      check("idle_busy_cnt", busy_cnt, 0);
      check("idle_done_cnt", done_cnt, 0);
      busy_cnt = 0; done_cnt = 0;
      cyc(1'b0, 1'b1, 8'hA5);
      idle_run(44);
      check("a5_busy_len", busy_cnt, 40);
      check("a5_done_cnt", done_cnt, 1);
      busy_cnt = 0; done_cnt = 0;
      cyc(1'b0, 1'b1, 8'h3C);
      for (int i = 1; i < 48; i++)
         cyc(1'b0, i == 12, (i >= 5) ? 8'hFF : 8'h3C);
      check("3c_busy_len", busy_cnt, 40);
      check("3c_done_cnt", done_cnt, 1);
      busy_cnt = 0; done_cnt = 0;
      cyc(1'b0, 1'b1, 8'h00);
      idle_run(40);
      check("b2b_done_first", int'(done), 1);
      cyc(1'b0, 1'b1, 8'hFF);
      idle_run(44);
      check("b2b_busy_len", busy_cnt, 80);
      check("b2b_done_cnt", done_cnt, 2);
      busy_cnt = 0; done_cnt = 0;
      cyc(1'b0, 1'b1, 8'h55);
      idle_run(17);
      cyc(1'b1, 1'b0, 8'h55);
      idle_run(30);
      check("abort_done_cnt", done_cnt, 0);
      cyc(1'b0, 1'b1, 8'h96);
      idle_run(44);
      check("clean_done_cnt", done_cnt, 1);
      busy_cnt = 0; done_cnt = 0;
      cyc(1'b1, 1'b1, 8'hC3);
      idle_run(10);
      check("rst_pulse_busy_cnt", busy_cnt, 0);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, 8'($urandom));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
